// File: rtl/stage4_r2sdf.sv
// Fourth radix-2 SDF stage (span 2, trivial W4 twiddle) of the 32-point DIF FFT pipeline.
// Define STAGE4_SOF_EN to add the registered start-of-frame output sof_o.
module stage4_r2sdf #(
    parameter int IN_W     = 16,
    parameter int OUT_W    = 17,
    parameter int SR_DEPTH = 2,
    parameter int FRAME    = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_i,
    input  logic signed [IN_W-1:0]  data_in_r,
    input  logic signed [IN_W-1:0]  data_in_i,
    output logic                    valid_o,
    output logic signed [OUT_W-1:0] data_out_r,
    output logic signed [OUT_W-1:0] data_out_i
`ifdef STAGE4_SOF_EN
    ,
    output logic                    sof_o
`endif
);

    localparam int CNT_W = $clog2(FRAME);
    localparam int PH    = $clog2(SR_DEPTH);

    logic                    valid_r_q, valid_r_d;
    logic signed [IN_W-1:0]  xr_q, xr_d;
    logic signed [IN_W-1:0]  xi_q, xi_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [OUT_W-1:0] sr_re_q [SR_DEPTH];
    logic signed [OUT_W-1:0] sr_re_d [SR_DEPTH];
    logic signed [OUT_W-1:0] sr_im_q [SR_DEPTH];
    logic signed [OUT_W-1:0] sr_im_d [SR_DEPTH];
    logic [SR_DEPTH-1:0]     sr_tag_q, sr_tag_d;
    logic                    vo_q, vo_d;
    logic signed [OUT_W-1:0] dor_q, dor_d;
    logic signed [OUT_W-1:0] doi_q, doi_d;
`ifdef STAGE4_SOF_EN
    logic                    sof_q, sof_d;
`endif

    logic signed [OUT_W-1:0] xe_r, xe_i, top_r, top_i;
    logic signed [OUT_W-1:0] sum_r, sum_i, dif_r, dif_i;
    logic                    drain, step, bfly;

    always_comb begin
        valid_r_d = valid_i;
        xr_d      = data_in_r;
        xi_d      = data_in_i;
        cnt_d     = cnt_q;
        sr_re_d   = sr_re_q;
        sr_im_d   = sr_im_q;
        sr_tag_d  = sr_tag_q;
        vo_d      = 1'b0;
        dor_d     = dor_q;
        doi_d     = doi_q;
`ifdef STAGE4_SOF_EN
        sof_d     = 1'b0;
`endif

        xe_r  = {{(OUT_W-IN_W){xr_q[IN_W-1]}}, xr_q};
        xe_i  = {{(OUT_W-IN_W){xi_q[IN_W-1]}}, xi_q};
        top_r = sr_re_q[SR_DEPTH-1];
        top_i = sr_im_q[SR_DEPTH-1];
        sum_r = top_r + xe_r;
        sum_i = top_i + xe_i;
        dif_r = top_r - xe_r;
        dif_i = top_i - xe_i;

        // Flush pending differences only at a frame boundary once input stops
        drain = !valid_r_q && (cnt_q == '0) && (|sr_tag_q);
        step  = valid_r_q || drain;
        bfly  = valid_r_q && cnt_q[PH];

        if (step) begin
            for (int k = SR_DEPTH - 1; k > 0; k--) begin
                sr_re_d[k]  = sr_re_q[k-1];
                sr_im_d[k]  = sr_im_q[k-1];
                sr_tag_d[k] = sr_tag_q[k-1];
            end
            if (valid_r_q) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (bfly) begin
                vo_d        = 1'b1;
                dor_d       = sum_r;
                doi_d       = sum_i;
                sr_tag_d[0] = 1'b1;
                if (cnt_q[0]) begin
                    sr_re_d[0] = dif_i;
                    sr_im_d[0] = -dif_r;
                end else begin
                    sr_re_d[0] = dif_r;
                    sr_im_d[0] = dif_i;
                end
`ifdef STAGE4_SOF_EN
                sof_d = (cnt_q == CNT_W'(2));
`endif
            end else begin
                vo_d        = sr_tag_q[SR_DEPTH-1];
                dor_d       = top_r;
                doi_d       = top_i;
                sr_tag_d[0] = 1'b0;
                sr_re_d[0]  = valid_r_q ? xe_r : '0;
                sr_im_d[0]  = valid_r_q ? xe_i : '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r_q <= 1'b0;
            xr_q      <= '0;
            xi_q      <= '0;
            cnt_q     <= '0;
            sr_tag_q  <= '0;
            vo_q      <= 1'b0;
            dor_q     <= '0;
            doi_q     <= '0;
            for (int k = 0; k < SR_DEPTH; k++) begin
                sr_re_q[k] <= '0;
                sr_im_q[k] <= '0;
            end
`ifdef STAGE4_SOF_EN
            sof_q     <= 1'b0;
`endif
        end else begin
            valid_r_q <= valid_r_d;
            xr_q      <= xr_d;
            xi_q      <= xi_d;
            cnt_q     <= cnt_d;
            sr_tag_q  <= sr_tag_d;
            vo_q      <= vo_d;
            dor_q     <= dor_d;
            doi_q     <= doi_d;
            for (int k = 0; k < SR_DEPTH; k++) begin
                sr_re_q[k] <= sr_re_d[k];
                sr_im_q[k] <= sr_im_d[k];
            end
`ifdef STAGE4_SOF_EN
            sof_q     <= sof_d;
`endif
        end
    end

    assign valid_o    = vo_q;
    assign data_out_r = dor_q;
    assign data_out_i = doi_q;
`ifdef STAGE4_SOF_EN
    assign sof_o      = sof_q;
`endif

endmodule
